multicycle_control_fsm: RTL and testbench

//  Main controller of the multicycle RV32I core. Sits between the instruction register and the

---
 rtl/multicycle_control_fsm_pkg.sv | 80 ++++++++
 rtl/multicycle_control_fsm_if.sv | 35 +++
 rtl/multicycle_control_fsm_imm_src_decoder.sv | 20 ++
 rtl/multicycle_control_fsm.sv | 146 ++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, FSM states and datapath selects.
// Pure type/constant package; no logic, no latency, no backpressure.
package multicycle_control_fsm_pkg;

   typedef enum logic [6:0] {
      LOAD        = 7'b0000011,
      I_TYPE_ALU  = 7'b0010011,
      S_TYPE      = 7'b0100011,
      R_TYPE      = 7'b0110011,
      B_TYPE      = 7'b1100011,
      I_TYPE_JALR = 7'b1100111,
      J_TYPE      = 7'b1101111
   } opcode_t;

   typedef enum logic [1:0] {
      LOAD_STORE = 2'b00,
      BRANCH     = 2'b01,
      MATH       = 2'b10
   } alu_op_t;

   typedef enum logic [1:0] {
      IMM_SRC_I_TYPE = 2'b00,
      IMM_SRC_S_TYPE = 2'b01,
      IMM_SRC_B_TYPE = 2'b10,
      IMM_SRC_J_TYPE = 2'b11
   } imm_src_t;

   typedef enum logic [1:0] {
      RES_ALUOUT    = 2'b00,
      RES_MEMDATA   = 2'b01,
      RES_ALURESULT = 2'b10
   } result_src_t;

   typedef enum logic [1:0] {
      SRC_A_PC    = 2'b00,
      SRC_A_OLDPC = 2'b01,
      SRC_A_RS1   = 2'b10
   } alu_src_a_t;

   typedef enum logic [1:0] {
      SRC_B_RS2  = 2'b00,
      SRC_B_IMM  = 2'b01,
      SRC_B_FOUR = 2'b10
   } alu_src_b_t;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXEC_R   = 4'd6,
      EXEC_I   = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JALR_ADR = 4'd10,
      JAL      = 4'd11,
      ILLEGAL  = 4'd12
   } state_t;

   localparam logic [2:0] FUN3_BEQ = 3'b000;

   // Per-state control word; pc_update and branch are internal terms folded into pc_write.
   typedef struct packed {
      logic        pc_update;
      logic        branch;
      logic        adr_src;
      logic        mem_write;
      logic        ir_write;
      result_src_t result_src;
      alu_src_a_t  alu_src_a;
      alu_src_b_t  alu_src_b;
      alu_op_t     alu_op;
      logic        reg_write;
      logic        illegal_instr;
      logic        instr_done;
   } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in, enables and selects out.
// Wires only; no latency, no backpressure.
interface multicycle_control_fsm_if;
   import multicycle_control_fsm_pkg::*;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        zero;
   logic        pc_write;
   logic        adr_src;
   logic        mem_write;
   logic        ir_write;
   result_src_t result_src;
   alu_src_a_t  alu_src_a;
   alu_src_b_t  alu_src_b;
   alu_op_t     alu_op;
   imm_src_t    imm_src;
   logic        reg_write;
   logic        illegal_instr;
   logic        instr_done;
   state_t      state_o;

   modport master (
      input  opcode, funct3, zero,
      output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
             alu_op, imm_src, reg_write, illegal_instr, instr_done, state_o
   );

   modport slave (
      output opcode, funct3, zero,
      input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
             alu_op, imm_src, reg_write, illegal_instr, instr_done, state_o
   );

endinterface

// File: rtl/multicycle_control_fsm_imm_src_decoder.sv
// Opcode -> immediate format select for the immediate extender.
// Combinational, zero latency; no backpressure.
module imm_src_decoder
   import multicycle_control_fsm_pkg::*;
(
   input  logic [6:0] opcode,
   output imm_src_t   imm_src
);

   always_comb begin
      imm_src = IMM_SRC_I_TYPE;
      case (opcode)
         S_TYPE:  imm_src = IMM_SRC_S_TYPE;
         B_TYPE:  imm_src = IMM_SRC_B_TYPE;
         J_TYPE:  imm_src = IMM_SRC_J_TYPE;
         default: imm_src = IMM_SRC_I_TYPE;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I main controller: Moore FSM driving every datapath enable/select (lw 5, sw 4, R/I 4,
// beq 3, jal 4, jalr 5 cycles); outputs decode the state register, pc_write also uses zero; no backpressure.
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   multicycle_control_fsm_if.master bus
);

   state_t   state_q;
   state_t   state_d;
   ctrl_t    ctrl;
   imm_src_t imm_src;

   imm_src_decoder u_imm_src_decoder (
      .opcode  (bus.opcode),
      .imm_src (imm_src)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      ctrl    = '0;
      state_d = FETCH;
      case (state_q)
         FETCH: begin
            ctrl.ir_write   = 1'b1;
            ctrl.alu_src_a  = SRC_A_PC;
            ctrl.alu_src_b  = SRC_B_FOUR;
            ctrl.alu_op     = LOAD_STORE;
            ctrl.result_src = RES_ALURESULT;
            ctrl.pc_update  = 1'b1;
            state_d         = DECODE;
         end
         DECODE: begin
            // Precompute the branch/jal target OldPC+imm while the opcode is decoded.
            ctrl.alu_src_a = SRC_A_OLDPC;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = LOAD_STORE;
            case (bus.opcode)
               LOAD, S_TYPE: state_d = MEMADR;
               R_TYPE:       state_d = EXEC_R;
               I_TYPE_ALU:   state_d = EXEC_I;
               J_TYPE:       state_d = JAL;
               B_TYPE:       state_d = (bus.funct3 == FUN3_BEQ) ? BEQ : ILLEGAL;
               I_TYPE_JALR:  state_d = JALR_ADR;
               default:      state_d = ILLEGAL;
            endcase
         end
         MEMADR: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = LOAD_STORE;
            state_d        = (bus.opcode == LOAD) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            ctrl.result_src = RES_ALUOUT;
            ctrl.adr_src    = 1'b1;
            state_d         = MEMWB;
         end
         MEMWB: begin
            ctrl.result_src = RES_MEMDATA;
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
            state_d         = FETCH;
         end
         MEMWRITE: begin
            ctrl.result_src = RES_ALUOUT;
            ctrl.adr_src    = 1'b1;
            ctrl.mem_write  = 1'b1;
            ctrl.instr_done = 1'b1;
            state_d         = FETCH;
         end
         EXEC_R: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_RS2;
            ctrl.alu_op    = MATH;
            state_d        = ALUWB;
         end
         EXEC_I: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = MATH;
            state_d        = ALUWB;
         end
         ALUWB: begin
            ctrl.result_src = RES_ALUOUT;
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
            state_d         = FETCH;
         end
         BEQ: begin
            ctrl.alu_src_a  = SRC_A_RS1;
            ctrl.alu_src_b  = SRC_B_RS2;
            ctrl.alu_op     = BRANCH;
            ctrl.result_src = RES_ALUOUT;
            ctrl.branch     = 1'b1;
            ctrl.instr_done = 1'b1;
            state_d         = FETCH;
         end
         JALR_ADR: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = LOAD_STORE;
            state_d        = JAL;
         end
         JAL: begin
            // PC takes the target held in ALUOut while the ALU forms OldPC+4 for rd.
            ctrl.alu_src_a  = SRC_A_OLDPC;
            ctrl.alu_src_b  = SRC_B_FOUR;
            ctrl.alu_op     = LOAD_STORE;
            ctrl.result_src = RES_ALUOUT;
            ctrl.pc_update  = 1'b1;
            state_d         = ALUWB;
         end
         ILLEGAL: begin
            ctrl.illegal_instr = 1'b1;
            state_d            = ILLEGAL;
         end
         default: state_d = FETCH;
      endcase
   end

   // Architectural writes are suppressed on the reset cycle so an abandoned instruction leaves no trace.
   assign bus.pc_write      = ~rst & (ctrl.pc_update | (ctrl.branch & bus.zero));
   assign bus.ir_write      = ~rst & ctrl.ir_write;
   assign bus.mem_write     = ~rst & ctrl.mem_write;
   assign bus.reg_write     = ~rst & ctrl.reg_write;
   assign bus.instr_done    = ~rst & ctrl.instr_done;
   assign bus.illegal_instr = ~rst & ctrl.illegal_instr;
   assign bus.adr_src       = ctrl.adr_src;
   assign bus.result_src    = ctrl.result_src;
   assign bus.alu_src_a     = ctrl.alu_src_a;
   assign bus.alu_src_b     = ctrl.alu_src_b;
   assign bus.alu_op        = ctrl.alu_op;
   assign bus.imm_src       = imm_src;
   assign bus.state_o       = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for the multicycle controller against an instruction-level reference model.
module tb_multicycle_control_fsm;
   import multicycle_control_fsm_pkg::*;

   typedef enum int {K_LW, K_SW, K_R, K_I, K_BEQ, K_JAL, K_JALR, K_ILL} kind_e;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   cyc;
   int   last_done_cyc;
   int   done_gap;

   multicycle_control_fsm_if bus ();

   multicycle_control_fsm dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic kind_e classify(input logic [6:0] op, input logic [2:0] f3);
      case (op)
         LOAD:        return K_LW;
         S_TYPE:      return K_SW;
         R_TYPE:      return K_R;
         I_TYPE_ALU:  return K_I;
         B_TYPE:      return (f3 == 3'b000) ? K_BEQ : K_ILL;
         J_TYPE:      return K_JAL;
         I_TYPE_JALR: return K_JALR;
         default:     return K_ILL;
      endcase
   endfunction

   function automatic int latency(input kind_e c);
      case (c)
         K_LW, K_JALR: return 5;
         K_BEQ:        return 3;
         default:      return 4;
      endcase
   endfunction

   // State visited in cycle k of an instruction of kind c.
   function automatic state_t trace(input kind_e c, input int k);
      if (k == 0) return FETCH;
      if (k == 1) return DECODE;
      case (c)
         K_LW:   return (k == 2) ? MEMADR : (k == 3) ? MEMREAD : MEMWB;
         K_SW:   return (k == 2) ? MEMADR : MEMWRITE;
         K_R:    return (k == 2) ? EXEC_R : ALUWB;
         K_I:    return (k == 2) ? EXEC_I : ALUWB;
         K_BEQ:  return BEQ;
         K_JAL:  return (k == 2) ? JAL : ALUWB;
         K_JALR: return (k == 2) ? JALR_ADR : (k == 3) ? JAL : ALUWB;
         default: return ILLEGAL;
      endcase
   endfunction

   function automatic imm_src_t exp_imm(input logic [6:0] op);
      case (op)
         S_TYPE:  return IMM_SRC_S_TYPE;
         B_TYPE:  return IMM_SRC_B_TYPE;
         J_TYPE:  return IMM_SRC_J_TYPE;
         default: return IMM_SRC_I_TYPE;
      endcase
   endfunction

   function automatic logic [6:0] enables();
      return {bus.ir_write, bus.pc_write, bus.adr_src, bus.mem_write,
              bus.reg_write, bus.instr_done, bus.illegal_instr};
   endfunction

   // Runs one legal instruction from its FETCH cycle; zmode 0/1 forces zero, 2 randomizes it.
   task automatic exec_instr(input logic [6:0] op, input logic [2:0] f3, input int zmode);
      kind_e       c;
      int          n;
      logic        z;
      logic [6:0]  exp_en;
      state_t      exp_st;
      alu_src_a_t  exp_a;
      alu_src_b_t  exp_b;
      alu_op_t     exp_op;
      result_src_t exp_res;
      logic        jump_pc;
      c = classify(op, f3);
      n = latency(c);
      for (int k = 0; k < n; k++) begin
         z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
         bus.opcode = op;
         bus.funct3 = f3;
         bus.zero   = z;
         #1;
         exp_st  = trace(c, k);
         jump_pc = (c == K_JAL && k == 2) || (c == K_JALR && k == 3);
         exp_en  = {k == 0,
                    (k == 0) || jump_pc || (c == K_BEQ && k == 2 && z),
                    (c == K_LW || c == K_SW) && k == 3,
                    c == K_SW && k == 3,
                    (k == n - 1) && c != K_SW && c != K_BEQ,
                    k == n - 1,
                    1'b0};
         exp_a   = (k == 0) ? SRC_A_PC : (k == 1) ? SRC_A_OLDPC :
                   jump_pc ? SRC_A_OLDPC : (k == 2) ? SRC_A_RS1 : SRC_A_PC;
         exp_b   = (k == 0) ? SRC_B_FOUR : (k == 1) ? SRC_B_IMM :
                   jump_pc ? SRC_B_FOUR :
                   (k == 2) ? ((c == K_R || c == K_BEQ) ? SRC_B_RS2 : SRC_B_IMM) : SRC_B_RS2;
         exp_op  = (k == 2 && (c == K_R || c == K_I)) ? MATH :
                   (k == 2 && c == K_BEQ) ? BRANCH : LOAD_STORE;
         exp_res = (k == 0) ? RES_ALURESULT : (c == K_LW && k == 4) ? RES_MEMDATA : RES_ALUOUT;

         checks += 6;
         if (bus.state_o !== exp_st) begin
            errors++;
            $display("FAIL state op=%b k=%0d got %0d exp %0d", op, k, bus.state_o, exp_st);
         end
         if (enables() !== exp_en) begin
            errors++;
            $display("FAIL enables op=%b k=%0d got %b exp %b", op, k, enables(), exp_en);
         end
         if (bus.alu_src_a !== exp_a || bus.alu_src_b !== exp_b) begin
            errors++;
            $display("FAIL alu_src op=%b k=%0d got a=%b b=%b exp a=%b b=%b",
                     op, k, bus.alu_src_a, bus.alu_src_b, exp_a, exp_b);
         end
         if (bus.alu_op !== exp_op) begin
            errors++;
            $display("FAIL alu_op op=%b k=%0d got %b exp %b", op, k, bus.alu_op, exp_op);
         end
         if (bus.result_src !== exp_res) begin
            errors++;
            $display("FAIL result_src op=%b k=%0d got %b exp %b", op, k, bus.result_src, exp_res);
         end
         if (bus.imm_src !== exp_imm(op)) begin
            errors++;
            $display("FAIL imm_src op=%b k=%0d got %b exp %b", op, k, bus.imm_src, exp_imm(op));
         end
         if (bus.instr_done === 1'b1) begin
            done_gap      = cyc - last_done_cyc;
            last_done_cyc = cyc;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      bus.opcode = LOAD;
      bus.funct3 = 3'b010;
      bus.zero   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checks += 2;
         if (enables() !== 7'b0) begin
            errors++;
            $display("FAIL reset_enables cycle=%0d got %b exp 0000000", i, enables());
         end
         if (bus.state_o !== FETCH) begin
            errors++;
            $display("FAIL reset_state cycle=%0d got %0d exp %0d", i, bus.state_o, FETCH);
         end
      end
      rst = 1'b0;
      #1;
      checks++;
      if (bus.state_o !== FETCH || bus.ir_write !== 1'b1) begin
         errors++;
         $display("FAIL reset_release got state=%0d ir_write=%b exp state=%0d ir_write=1",
                  bus.state_o, bus.ir_write, FETCH);
      end
   endtask

   task automatic test_load();
      exec_instr(LOAD, 3'b010, 2);
   endtask

   task automatic test_store();
      exec_instr(S_TYPE, 3'b010, 2);
   endtask

   task automatic test_branch();
      exec_instr(B_TYPE, 3'b000, 1);
      exec_instr(B_TYPE, 3'b000, 0);
   endtask

   task automatic test_jumps();
      exec_instr(J_TYPE, 3'b000, 2);
      exec_instr(I_TYPE_JALR, 3'b000, 2);
   endtask

   task automatic test_back_to_back();
      exec_instr(R_TYPE, 3'b000, 2);
      exec_instr(I_TYPE_ALU, 3'b111, 2);
      checks++;
      if (done_gap !== 4) begin
         errors++;
         $display("FAIL done_gap_r_i got %0d exp 4", done_gap);
      end
      exec_instr(R_TYPE, 3'b100, 2);
      checks++;
      if (done_gap !== 4) begin
         errors++;
         $display("FAIL done_gap_i_r got %0d exp 4", done_gap);
      end
   endtask

   task automatic test_random();
      logic [6:0] ops [7];
      logic [6:0] op;
      logic [2:0] f3;
      ops = '{LOAD, S_TYPE, R_TYPE, I_TYPE_ALU, B_TYPE, J_TYPE, I_TYPE_JALR};
      for (int i = 0; i < 40; i++) begin
         op = ops[$urandom_range(0, 6)];
         f3 = 3'($urandom_range(0, 7));
         if (op == B_TYPE) f3 = 3'b000;
         exec_instr(op, f3, 2);
      end
   endtask

   task automatic test_illegal();
      logic [6:0] bad_op [3];
      logic [2:0] bad_f3 [3];
      bad_op = '{B_TYPE, 7'b0110111, 7'b0000000};
      bad_f3 = '{3'b001, 3'b000, 3'($urandom_range(0, 7))};
      for (int t = 0; t < 3; t++) begin
         bus.opcode = bad_op[t];
         bus.funct3 = bad_f3[t];
         bus.zero   = 1'($urandom_range(0, 1));
         #1;
         @(negedge clk);
         #1;
         checks++;
         if (bus.state_o !== DECODE) begin
            errors++;
            $display("FAIL illegal_decode op=%b got %0d exp %0d", bad_op[t], bus.state_o, DECODE);
         end
         @(negedge clk);
         for (int i = 0; i < 10; i++) begin
            bus.zero = 1'($urandom_range(0, 1));
            #1;
            checks += 2;
            if (bus.state_o !== ILLEGAL) begin
               errors++;
               $display("FAIL illegal_state op=%b i=%0d got %0d exp %0d",
                        bad_op[t], i, bus.state_o, ILLEGAL);
            end
            if (enables() !== 7'b0000001) begin
               errors++;
               $display("FAIL illegal_outputs op=%b i=%0d got %b exp 0000001", bad_op[t], i, enables());
            end
            @(negedge clk);
         end
         rst = 1'b1;
         #1;
         checks++;
         if (bus.illegal_instr !== 1'b0) begin
            errors++;
            $display("FAIL illegal_in_reset got %b exp 0", bus.illegal_instr);
         end
         @(negedge clk);
         #1;
         checks++;
         if (bus.state_o !== FETCH) begin
            errors++;
            $display("FAIL illegal_exit got %0d exp %0d", bus.state_o, FETCH);
         end
         rst = 1'b0;
      end
   endtask

   task automatic test_mid_reset();
      bus.opcode = S_TYPE;
      bus.funct3 = 3'b010;
      for (int k = 0; k < 3; k++) begin
         #1;
         @(negedge clk);
      end
      #1;
      checks++;
      if (bus.state_o !== MEMWRITE || bus.mem_write !== 1'b1) begin
         errors++;
         $display("FAIL midrst_pre got state=%0d mem_write=%b exp state=%0d mem_write=1",
                  bus.state_o, bus.mem_write, MEMWRITE);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.mem_write !== 1'b0 || bus.instr_done !== 1'b0 || bus.pc_write !== 1'b0) begin
         errors++;
         $display("FAIL midrst_writes got mem_write=%b instr_done=%b pc_write=%b exp 0 0 0",
                  bus.mem_write, bus.instr_done, bus.pc_write);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.state_o !== FETCH) begin
         errors++;
         $display("FAIL midrst_state got %0d exp %0d", bus.state_o, FETCH);
      end
      rst = 1'b0;
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      cyc           = 0;
      last_done_cyc = 0;
      done_gap      = 0;
      rst           = 1'b1;
      bus.opcode    = LOAD;
      bus.funct3    = 3'b000;
      bus.zero      = 1'b0;
      test_reset();
      test_load();
      test_store();
      test_branch();
      test_jumps();
      test_back_to_back();
      test_random();
      test_illegal();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
